// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the pipelined mux tree
// Provides: clog4 (tree depth), selw (select/tag width), lvl_off (flat stage
// offset of a tree level), SCAN_CNT_RST (scan counter reset value).
package mux_pkg;

  localparam int SCAN_CNT_RST = 0;

  // Number of 4:1 levels needed to reduce n channels to one.
  function automatic int clog4(input int n);
    int l;
    l = 0;
    for (int v = 1; v < n; v = v * 4) begin
      l++;
    end
    return l;
  endfunction

  function automatic int selw(input int n);
    return 2 * clog4(n);
  endfunction

  // Index of the first stage of level lvl when all stages are numbered
  // level by level, level 0 first.
  function automatic int lvl_off(input int channels, input int lvl);
    int off;
    int n;
    off = 0;
    n   = channels / 4;
    for (int i = 0; i < lvl; i++) begin
      off = off + n;
      n   = n / 4;
    end
    return off;
  endfunction

endpackage

// File: rtl/mux4_stage.sv
// rtl/mux4_stage.sv - registered 4:1 word mux with valid and tag
// Ports: clk, rst (async active-high), i_en (advance), i_sel (2-bit select),
//   i_data (4 words), i_tag (4 tags), i_valid (4 valids);
//   o_data/o_tag/o_valid: registered selected word, tag and valid.
module mux4_stage #(
  parameter int WIDTH = 8,
  parameter int TAGW  = 1
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic [1:0]          i_sel,
  input  logic [4*WIDTH-1:0]  i_data,
  input  logic [4*TAGW-1:0]   i_tag,
  input  logic [3:0]          i_valid,
  output logic [WIDTH-1:0]    o_data,
  output logic [TAGW-1:0]     o_tag,
  output logic                o_valid
);

  logic [WIDTH-1:0] r_data;
  logic [TAGW-1:0]  r_tag;
  logic             r_valid;

  // Tag and valid are muxed alongside the data so every child's sideband is
  // consumed; children of one level always carry identical sideband anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_tag   <= '0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_data  <= i_data[i_sel*WIDTH +: WIDTH];
      r_tag   <= i_tag[i_sel*TAGW +: TAGW];
      r_valid <= i_valid[i_sel];
    end
  end

  assign o_data  = r_data;
  assign o_tag   = r_tag;
  assign o_valid = r_valid;

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N:1 word mux tree with auto-scan
// Ports: clk, rst (async active-high), data_in (flat channel bus), sel,
//   in_valid (direct-mode request), scan_en, scan_start, stall;
//   out_data, out_sel (source channel), out_valid, scan_done (last channel of scan).
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 16,
  localparam int LEVELS   = clog4(CHANNELS),
  localparam int SELW     = selw(CHANNELS)
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SELW-1:0]           sel,
  input  logic                      in_valid,
  input  logic                      scan_en,
  input  logic                      scan_start,
  input  logic                      stall,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  output logic                      scan_done
);

  // Tag = {scan_done flag, effective select}.
  localparam int TAGW = SELW + 1;
  localparam int NST  = (CHANNELS - 1) / 3;

  logic [SELW-1:0]      r_scan_cnt;
  logic [SELW-1:0]      w_scan_sel;
  logic [SELW-1:0]      w_esel;
  logic                 w_evalid;
  logic                 w_done;
  logic                 w_en;
  logic [TAGW-1:0]      w_tag0;

  logic [NST*WIDTH-1:0] w_st_data;
  logic [NST*TAGW-1:0]  w_st_tag;
  logic [NST-1:0]       w_st_valid;

  assign w_en       = ~stall;
  // scan_start overrides the counter for this very sample, which also makes
  // a restart on the wrap cycle land on channel 0 without a scan_done.
  assign w_scan_sel = scan_start ? '0 : r_scan_cnt;
  assign w_esel     = scan_en ? w_scan_sel : sel;
  assign w_evalid   = scan_en | in_valid;
  assign w_done     = scan_en && (w_scan_sel == SELW'(CHANNELS - 1));
  assign w_tag0     = {w_done, w_esel};

  // Counter width equals log2(CHANNELS), so the increment wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= SELW'(SCAN_CNT_RST);
    end else if (scan_en && !stall) begin
      r_scan_cnt <= w_scan_sel + SELW'(1);
    end
  end

  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int N    = CHANNELS >> (2 * (j + 1));
    localparam int OFF  = lvl_off(CHANNELS, j);
    localparam int POFF = (j > 0) ? lvl_off(CHANNELS, j - 1) : 0;

    logic [4*N*WIDTH-1:0] w_in_data;
    logic [4*N*TAGW-1:0]  w_in_tag;
    logic [4*N-1:0]       w_in_valid;
    logic [1:0]           w_sel;

    if (j == 0) begin : g_first
      assign w_in_data  = data_in;
      assign w_in_tag   = {(4*N){w_tag0}};
      assign w_in_valid = {(4*N){w_evalid}};
      assign w_sel      = w_esel[1:0];
    end else begin : g_next
      assign w_in_data  = w_st_data[POFF*WIDTH +: 4*N*WIDTH];
      assign w_in_tag   = w_st_tag[POFF*TAGW +: 4*N*TAGW];
      assign w_in_valid = w_st_valid[POFF +: 4*N];
      // Select bits for this level ride in the tag of the previous level.
      assign w_sel      = w_st_tag[POFF*TAGW + 2*j +: 2];
    end

    for (genvar s = 0; s < N; s++) begin : g_st
      mux4_stage #(
        .WIDTH (WIDTH),
        .TAGW  (TAGW)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_sel   (w_sel),
        .i_data  (w_in_data[s*4*WIDTH +: 4*WIDTH]),
        .i_tag   (w_in_tag[s*4*TAGW +: 4*TAGW]),
        .i_valid (w_in_valid[s*4 +: 4]),
        .o_data  (w_st_data[(OFF+s)*WIDTH +: WIDTH]),
        .o_tag   (w_st_tag[(OFF+s)*TAGW +: TAGW]),
        .o_valid (w_st_valid[OFF+s])
      );
    end
  end

  assign out_data  = w_st_data[(NST-1)*WIDTH +: WIDTH];
  assign out_sel   = w_st_tag[(NST-1)*TAGW +: SELW];
  assign scan_done = w_st_tag[(NST-1)*TAGW + SELW];
  assign out_valid = w_st_valid[NST-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - scoreboard bench for mux_tree_pipe (16 x 8-bit)
module tb_mux_tree_pipe;

  localparam int WIDTH = 8;
  localparam int CH    = 16;
  localparam int SELW  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [CH*WIDTH-1:0] data_in;
  logic [SELW-1:0]     sel;
  logic                in_valid;
  logic                scan_en;
  logic                scan_start;
  logic                stall;
  logic [WIDTH-1:0]    out_data;
  logic [SELW-1:0]     out_sel;
  logic                out_valid;
  logic                scan_done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] s;
    logic       done;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_cnt = 4'd0;
  bit         upd_q = 1'b0;

  always #5 clk = ~clk;

  mux_tree_pipe #(
    .WIDTH    (WIDTH),
    .CHANNELS (CH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .sel        (sel),
    .in_valid   (in_valid),
    .scan_en    (scan_en),
    .scan_start (scan_start),
    .stall      (stall),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_valid  (out_valid),
    .scan_done  (scan_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] ch, input logic dn);
    exp_t e;
    e.d    = data_in[ch*8 +: 8];
    e.s    = ch;
    e.done = dn;
    return e;
  endfunction

  // Reference model: decides which sample enters at each edge.
  always @(posedge clk) begin : model
    logic [3:0] ch;
    upd_q = !stall && !rst;
    if (rst) begin
      sb.delete();
      m_cnt = 4'd0;
    end else if (!stall) begin
      if (scan_en) begin
        ch = scan_start ? 4'd0 : m_cnt;
        sb.push_back(mk(ch, ch == 4'd15));
        m_cnt = ch + 4'd1;
      end else if (in_valid) begin
        sb.push_back(mk(sel, 1'b0));
      end
    end
  end

  // Output monitor: a held beat during stall is not a new beat.
  always @(negedge clk) begin : mon
    exp_t e;
    if (upd_q && out_valid) begin
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_data", 32'(out_data), 32'(e.d));
        check("sb_sel", 32'(out_sel), 32'(e.s));
        check("sb_done", 32'(scan_done), 32'(e.done));
      end
    end
  end

  initial begin
    bit found;
    rst        = 1'b1;
    sel        = '0;
    in_valid   = 1'b0;
    scan_en    = 1'b0;
    scan_start = 1'b0;
    stall      = 1'b0;
    for (int k = 0; k < CH; k++) data_in[k*8 +: 8] = 8'hA0 + 8'(k);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_sel", 32'(out_sel), 32'd0);
    check("rst_done", 32'(scan_done), 32'd0);
    rst = 1'b0;

    // Direct single sample; data change after acceptance must not leak in
    @(negedge clk);
    sel = 4'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; data_in[5*8 +: 8] = 8'h55;
    check("dir_lat1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("dir_lat2_valid", 32'(out_valid), 32'd1);
    check("dir_data", 32'(out_data), 32'hA5);
    check("dir_sel", 32'(out_sel), 32'd5);
    @(negedge clk);
    check("dir_one_beat", 32'(out_valid), 32'd0);
    data_in[5*8 +: 8] = 8'hA5;

    // Back-to-back streaming of all channels
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sel = 4'(i); in_valid = 1'b1;
      if (i >= 2) check("stream_nogap", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("stream_tail14", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("stream_tail15", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("stream_end", 32'(out_valid), 32'd0);

    // Auto-scan, then stall for 3 cycles at out_sel=7
    scan_en = 1'b1; scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && out_sel == 4'd7) begin found = 1'b1; break; end
    end
    check("wait_sel7", 32'(found), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold_sel", 32'(out_sel), 32'd7);
      check("stall_hold_valid", 32'(out_valid), 32'd1);
    end
    stall = 1'b0;
    @(negedge clk);
    check("stall_resume_sel", 32'(out_sel), 32'd8);

    // scan_start on the wrap cycle
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_cnt == 4'd15) begin found = 1'b1; break; end
    end
    check("wait_cnt15", 32'(found), 32'd1);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    @(negedge clk);
    check("collide_sel", 32'(out_sel), 32'd0);
    check("collide_data", 32'(out_data), 32'hA0);
    check("collide_done", 32'(scan_done), 32'd0);

    // Async reset mid-stream
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_done", 32'(scan_done), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(out_valid), 32'd0);
    sel = 4'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("post_rst_lat2", 32'(out_valid), 32'd1);
    check("post_rst_data", 32'(out_data), 32'hA3);

    for (int i = 0; i < 4; i++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
